// File: rtl/cpu_run_controller.sv
// Run/halt/single-step controller: debounces active-low push-buttons and
// sequences the CPU reset and clock enable (CPU clock is gated, never muxed).

module cpu_run_debounce #(
  parameter int DEBOUNCE_CYCLES = 65535
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          pressed;

  // Pin is active-low; compare in "1 = pressed" terms against the level.
  assign pressed = ~sync_q[1];

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (pressed != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = pressed;
        press_d = pressed;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;
endmodule

module cpu_run_controller #(
  parameter int NUM_BTN           = 2,
  parameter int DEBOUNCE_CYCLES   = 65535,
  parameter int RESET_HOLD_CYCLES = 16,
  parameter int STEP_CYCLES       = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_BTN-1:0] btn_i,
  input  logic               halt_req_i,
  output logic               cpu_rst_n_o,
  output logic               cpu_clk_en_o,
  output logic [NUM_BTN-1:0] btn_level_o,
  output logic [NUM_BTN-1:0] btn_press_o,
  output logic [1:0]         run_state_o
);
  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_STEP  = 2'd3
  } state_e;

  // One counter serves both the reset hold and the step length.
  localparam int MAXC = (RESET_HOLD_CYCLES > STEP_CYCLES) ? RESET_HOLD_CYCLES : STEP_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);

  logic [NUM_BTN-1:0] press;
  state_e             state_q, state_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic               rst_n_q, rst_n_d;
  logic               en_q, en_d;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    cpu_run_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .btn_i   (btn_i[g]),
      .level_o (btn_level_o[g]),
      .press_o (press[g])
    );
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q + 1'b1;
    // Restart wins over everything and re-arms the full hold.
    if (press[0]) begin
      state_d = ST_RESET;
      tcnt_d  = '0;
    end else begin
      case (state_q)
        ST_RESET: if (tcnt_q == TW'(RESET_HOLD_CYCLES - 1)) begin
          state_d = ST_RUN;
          tcnt_d  = '0;
        end
        ST_RUN: begin
          tcnt_d = '0;
          if (press[1] || halt_req_i) state_d = ST_HALT;
        end
        ST_HALT: begin
          tcnt_d = '0;
          if (press[1]) state_d = ST_STEP;
        end
        ST_STEP: if (tcnt_q == TW'(STEP_CYCLES - 1)) begin
          state_d = ST_HALT;
          tcnt_d  = '0;
        end
        default: begin
          state_d = ST_RESET;
          tcnt_d  = '0;
        end
      endcase
    end
    // Outputs follow the next state so they change with run_state.
    rst_n_d = (state_d != ST_RESET);
    en_d    = (state_d == ST_RUN) || (state_d == ST_STEP);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_RESET;
      tcnt_q  <= '0;
      rst_n_q <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      rst_n_q <= rst_n_d;
      en_q    <= en_d;
    end
  end

  assign cpu_rst_n_o  = rst_n_q;
  assign cpu_clk_en_o = en_q;
  assign btn_press_o  = press;
  assign run_state_o  = state_q;
endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed scenarios plus randomized button/halt traffic, checked every cycle
// against a behavioural model of the debounce rules and run/halt/step modes.

module tb_cpu_run_controller;
  localparam int NB = 3;
  localparam int DB = 4;
  localparam int RH = 3;
  localparam int SC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] btn = '1;
  logic          halt_req = 1'b0;
  logic          cpu_rst_n, cpu_clk_en;
  logic [NB-1:0] btn_level, btn_press;
  logic [1:0]    run_state;

  int n_chk = 0;
  int n_pass = 0;

  cpu_run_controller #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(DB), .RESET_HOLD_CYCLES(RH), .STEP_CYCLES(SC)
  ) dut (
    .clk_i        (clk),
    .reset_i      (rst_n),
    .btn_i        (btn),
    .halt_req_i   (halt_req),
    .cpu_rst_n_o  (cpu_rst_n),
    .cpu_clk_en_o (cpu_clk_en),
    .btn_level_o  (btn_level),
    .btn_press_o  (btn_press),
    .run_state_o  (run_state)
  );

  always #5 clk = ~clk;

  // Model: mode 0 RESET, 1 RUN, 2 HALT, 3 STEP; m_left counts down cycles left.
  logic [NB-1:0] m_s1, m_s2, m_lvl, m_prs;
  int            m_run [NB];
  int            m_mode, m_left;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic m_reset();
    m_s1 = '1; m_s2 = '1; m_lvl = '0; m_prs = '0;
    for (int i = 0; i < NB; i++) m_run[i] = 0;
    m_mode = 0; m_left = RH;
  endtask

  task automatic m_step();
    logic [NB-1:0] prs_old;
    prs_old = m_prs;
    if (prs_old[0]) begin
      m_mode = 0; m_left = RH;
    end else begin
      case (m_mode)
        0: begin m_left--; if (m_left == 0) m_mode = 1; end
        1: if (prs_old[1] || halt_req) m_mode = 2;
        2: if (prs_old[1]) begin m_mode = 3; m_left = SC; end
        default: begin m_left--; if (m_left == 0) m_mode = 2; end
      endcase
    end
    // A new level is accepted after DB consecutive disagreeing sync samples.
    m_prs = '0;
    for (int i = 0; i < NB; i++) begin
      if (!m_s2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_lvl[i] = ~m_lvl[i];
          m_prs[i] = m_lvl[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = btn;
  endtask

  task automatic check_outs();
    chk("run_state",  32'(run_state),  32'(m_mode));
    chk("cpu_rst_n",  32'(cpu_rst_n),  32'(m_mode != 0));
    chk("cpu_clk_en", 32'(cpu_clk_en), 32'(m_mode == 1 || m_mode == 3));
    chk("btn_level",  32'(btn_level),  32'(m_lvl));
    chk("btn_press",  32'(btn_press),  32'(m_prs));
  endtask

  int en_cnt = 0;

  // One clock: model steps on the edge, outputs compared on the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (!rst_n) m_reset(); else m_step();
    @(negedge clk);
    if (cpu_clk_en) en_cnt++;
    check_outs();
  endtask

  task automatic press(input logic [NB-1:0] mask, input int hold);
    btn = btn & ~mask;
    repeat (hold) cyc();
    btn = btn | mask;
    repeat (8) cyc();
  endtask

  // Asynchronous reset between edges: outputs must drop with no clock edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("async_state", 32'(run_state),  32'd0);
    chk("async_rst_n", 32'(cpu_rst_n),  32'd0);
    chk("async_en",    32'(cpu_clk_en), 32'd0);
    chk("async_press", 32'(btn_press),  32'd0);
    m_reset();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    int hold_left [NB];
    int guard;
    m_reset();
    repeat (2) cyc();
    chk("reset_state", 32'(run_state), 32'd0);
    rst_n = 1'b1;

    // Reset release: hold for RH edges, then RUN.
    repeat (2) cyc();
    chk("hold_rst_n", 32'(cpu_rst_n), 32'd0);
    cyc();
    chk("release_run", 32'(run_state), 32'd1);
    chk("release_en",  32'(cpu_clk_en), 32'd1);

    // Glitch of 3 samples is filtered.
    btn[1] = 1'b0; repeat (3) cyc(); btn[1] = 1'b1;
    repeat (8) cyc();
    chk("glitch_run", 32'(run_state), 32'd1);

    // Clean press on the halt/step channel halts.
    press(3'b010, 10);
    chk("press_halt", 32'(run_state), 32'd2);

    // Single step: clock enable high exactly SC cycles, halt_req ignored in STEP.
    en_cnt = 0;
    halt_req = 1'b1;
    press(3'b010, 8);
    halt_req = 1'b0;
    chk("step_len", 32'(en_cnt), 32'(SC));
    chk("step_halt", 32'(run_state), 32'd2);

    // Restart, then software halt and a held halt_req in HALT.
    press(3'b001, 8);
    repeat (4) cyc();
    chk("restart_run", 32'(run_state), 32'd1);
    halt_req = 1'b1; cyc(); halt_req = 1'b0; cyc();
    chk("sw_halt", 32'(run_state), 32'd2);
    halt_req = 1'b1; repeat (5) cyc(); halt_req = 1'b0;
    chk("halt_held", 32'(run_state), 32'd2);

    // Restart and step presses in the same cycle: restart wins.
    btn[1:0] = 2'b00;
    repeat (6) cyc();
    chk("both_press", 32'(btn_press[1:0]), 32'd3);
    cyc();
    chk("prio_reset", 32'(run_state), 32'd0);
    btn[1:0] = 2'b11;
    repeat (3) cyc();
    chk("prio_run", 32'(run_state), 32'd1);
    repeat (6) cyc();

    // Reset asserted mid-step.
    halt_req = 1'b1; cyc(); halt_req = 1'b0;
    btn[1] = 1'b0;
    guard = 0;
    while (m_mode != 3 && guard < 20) begin cyc(); guard++; end
    chk("reach_step", 32'(m_mode), 32'd3);
    async_reset();
    btn[1] = 1'b1;
    repeat (12) cyc();

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < NB; i++) hold_left[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NB; i++) begin
        if (hold_left[i] == 0) begin
          if (i == 0) btn[i] = ($urandom_range(0, 7) != 0);
          else        btn[i] = ($urandom_range(0, 2) != 0);
          hold_left[i] = $urandom_range(1, 10);
        end
        hold_left[i]--;
      end
      halt_req = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 599) == 0) async_reset();
      else cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
